// File: rtl/ga_pkg.sv
// Shared GA constants and the tournament FSM state encoding.
package ga_pkg;

  localparam int FIT_W        = 27;
  localparam int POP_SIZE_DEF = 16;
  localparam int IDX_W_DEF    = $clog2(POP_SIZE_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_A,
    S_ADDR_B,
    S_DATA_B,
    S_CMP,
    S_RESULT,
    S_DONE
  } state_t;

endpackage

// File: rtl/tournament_driver_if.sv
// Request, fitness-RAM and comparator signals of the tournament driver.
interface tournament_driver_if #(
  parameter int IDX_W = ga_pkg::IDX_W_DEF,
  parameter int FIT_W = ga_pkg::FIT_W
);

  logic                    start;
  logic [IDX_W-1:0]        rand_a;
  logic [IDX_W-1:0]        rand_b;
  logic [IDX_W-1:0]        fit_addr;
  logic signed [FIT_W-1:0] fit_data;
  logic signed [FIT_W-1:0] sel_fitness1;
  logic signed [FIT_W-1:0] sel_fitness2;
  logic                    sel_enable;
  logic                    sel_selected;
  logic [IDX_W-1:0]        parent0_idx;
  logic [IDX_W-1:0]        parent1_idx;
  logic                    parent_valid;
  logic                    busy;

  modport master (
    output start, rand_a, rand_b, fit_data, sel_selected,
    input  fit_addr, sel_fitness1, sel_fitness2, sel_enable,
           parent0_idx, parent1_idx, parent_valid, busy
  );

  modport slave (
    input  start, rand_a, rand_b, fit_data, sel_selected,
    output fit_addr, sel_fitness1, sel_fitness2, sel_enable,
           parent0_idx, parent1_idx, parent_valid, busy
  );

endinterface

// File: rtl/tournament_idx_fold.sv
// Folds raw LFSR indices into the population range and forces the two
// candidates of a tournament to be distinct.
module tournament_idx_fold #(
  parameter int POP_SIZE = ga_pkg::POP_SIZE_DEF,
  parameter int IDX_W    = $clog2(POP_SIZE)
) (
  input  logic [IDX_W-1:0] rand_a,
  input  logic [IDX_W-1:0] rand_b,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b
);

  localparam logic [IDX_W:0]   POP_EXT  = (IDX_W+1)'(POP_SIZE);
  localparam logic [IDX_W-1:0] POP_LO   = IDX_W'(POP_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

  logic [IDX_W-1:0] w_a_fold;
  logic [IDX_W-1:0] w_b_fold;

  // raw index < 2*POP_SIZE, so one modular subtraction is enough
  always_comb begin
    w_a_fold = ({1'b0, rand_a} >= POP_EXT) ? (rand_a - POP_LO) : rand_a;
    w_b_fold = ({1'b0, rand_b} >= POP_EXT) ? (rand_b - POP_LO) : rand_b;
    idx_a    = w_a_fold;
    idx_b    = w_b_fold;
    if (w_b_fold == w_a_fold) begin
      idx_b = (w_a_fold == LAST_IDX) ? '0 : (w_a_fold + IDX_W'(1));
    end
  end

endmodule

// File: rtl/tournament_driver.sv
// Runs two binary tournaments per request and returns the two winner indices.
//
//   state    | meaning
//   IDLE     | waiting for start
//   ADDR_A   | fit_addr = candidate A
//   ADDR_B   | fit_addr = candidate B, capture fitness A
//   DATA_B   | capture fitness B, load comparator operands
//   CMP      | sel_enable pulse
//   RESULT   | latch winner, next tournament or finish
//   DONE     | parent_valid pulse
module tournament_driver #(
  parameter int POP_SIZE = ga_pkg::POP_SIZE_DEF,
  parameter int IDX_W    = $clog2(POP_SIZE),
  parameter int FIT_W    = ga_pkg::FIT_W
) (
  input  logic clk,
  input  logic rst_n,
  tournament_driver_if.slave bus
);

  import ga_pkg::*;

  state_t                  r_state;
  logic                    r_cnt;
  logic [IDX_W-1:0]        r_idx_a;
  logic [IDX_W-1:0]        r_idx_b;
  logic signed [FIT_W-1:0] r_fa;
  logic [IDX_W-1:0]        r_fit_addr;
  logic signed [FIT_W-1:0] r_sel_f1;
  logic signed [FIT_W-1:0] r_sel_f2;
  logic                    r_sel_enable;
  logic [IDX_W-1:0]        r_parent0;
  logic [IDX_W-1:0]        r_parent1;
  logic                    r_parent_valid;
  logic                    r_busy;

  logic [IDX_W-1:0]        w_fold_a;
  logic [IDX_W-1:0]        w_fold_b;
  logic [IDX_W-1:0]        w_winner;

  tournament_idx_fold #(
    .POP_SIZE (POP_SIZE),
    .IDX_W    (IDX_W)
  ) u_fold (
    .rand_a (bus.rand_a),
    .rand_b (bus.rand_b),
    .idx_a  (w_fold_a),
    .idx_b  (w_fold_b)
  );

  assign w_winner = bus.sel_selected ? r_idx_b : r_idx_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 1'b0;
      r_idx_a        <= '0;
      r_idx_b        <= '0;
      r_fa           <= '0;
      r_fit_addr     <= '0;
      r_sel_f1       <= '0;
      r_sel_f2       <= '0;
      r_sel_enable   <= 1'b0;
      r_parent0      <= '0;
      r_parent1      <= '0;
      r_parent_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_sel_enable   <= 1'b0;
      r_parent_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt      <= 1'b0;
            r_idx_a    <= w_fold_a;
            r_idx_b    <= w_fold_b;
            r_fit_addr <= w_fold_a;
            r_busy     <= 1'b1;
            r_state    <= S_ADDR_A;
          end
        end
        S_ADDR_A: begin
          r_fit_addr <= r_idx_b;
          r_state    <= S_ADDR_B;
        end
        S_ADDR_B: begin
          r_fa    <= bus.fit_data;
          r_state <= S_DATA_B;
        end
        // fitness B goes straight into the comparator operand register
        S_DATA_B: begin
          r_sel_f1     <= r_fa;
          r_sel_f2     <= bus.fit_data;
          r_sel_enable <= 1'b1;
          r_state      <= S_CMP;
        end
        S_CMP: begin
          r_state <= S_RESULT;
        end
        S_RESULT: begin
          if (!r_cnt) begin
            r_parent0  <= w_winner;
            r_cnt      <= 1'b1;
            r_idx_a    <= w_fold_a;
            r_idx_b    <= w_fold_b;
            r_fit_addr <= w_fold_a;
            r_state    <= S_ADDR_A;
          end else begin
            r_parent1      <= w_winner;
            r_parent_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fit_addr     = r_fit_addr;
  assign bus.sel_fitness1 = r_sel_f1;
  assign bus.sel_fitness2 = r_sel_f2;
  assign bus.sel_enable   = r_sel_enable;
  assign bus.parent0_idx  = r_parent0;
  assign bus.parent1_idx  = r_parent1;
  assign bus.parent_valid = r_parent_valid;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_tournament_driver.sv
// Directed bench for tournament_driver: RAM and minimising comparator models,
// expected parent pairs queued at request time and popped on parent_valid.
module tb_tournament_driver;

  import ga_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  tournament_driver_if #(.IDX_W(4), .FIT_W(FIT_W)) b16 ();
  tournament_driver_if #(.IDX_W(4), .FIT_W(FIT_W)) b12 ();

  tournament_driver #(.POP_SIZE(16), .IDX_W(4), .FIT_W(FIT_W)) dut16 (
    .clk (clk), .rst_n (rst_n), .bus (b16)
  );
  tournament_driver #(.POP_SIZE(12), .IDX_W(4), .FIT_W(FIT_W)) dut12 (
    .clk (clk), .rst_n (rst_n), .bus (b12)
  );

  logic signed [FIT_W-1:0] mem16 [16];
  logic signed [FIT_W-1:0] mem12 [12];

  // lower fitness wins, ties go to B
  always_ff @(posedge clk) begin
    b16.fit_data     <= mem16[b16.fit_addr];
    b12.fit_data     <= (b12.fit_addr < 4'd12) ? mem12[b12.fit_addr] : '0;
    b16.sel_selected <= b16.sel_enable && (b16.sel_fitness2 <= b16.sel_fitness1);
    b12.sel_selected <= b12.sel_enable && (b12.sel_fitness2 <= b12.sel_fitness1);
  end

  typedef struct packed {
    logic [3:0] p0;
    logic [3:0] p1;
  } pair_t;

  pair_t q16[$];
  pair_t q12[$];

  int checks   = 0;
  int failures = 0;
  int cyc, pv16_cnt, pv16_first, pv16_last, en16_cnt, pv12_cnt, pv12_last;
  logic [3:0]              addr16 [32];
  logic [3:0]              addr12 [32];
  logic                    en16   [32];
  logic signed [FIT_W-1:0] f1_16  [32];
  logic signed [FIT_W-1:0] f2_16  [32];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cyc = 0; pv16_cnt = 0; pv16_first = -1; pv16_last = -1; en16_cnt = 0;
    pv12_cnt = 0; pv12_last = -1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (cyc < 32) begin
      addr16[cyc] = b16.fit_addr;
      addr12[cyc] = b12.fit_addr;
      en16[cyc]   = b16.sel_enable;
      f1_16[cyc]  = b16.sel_fitness1;
      f2_16[cyc]  = b16.sel_fitness2;
    end
    if (b16.sel_enable) en16_cnt++;
    if (b16.parent_valid) begin
      pv16_cnt++;
      if (pv16_cnt == 1) pv16_first = cyc;
      pv16_last = cyc;
      chk("sb16_pending", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        pair_t e;
        e = q16.pop_front();
        chk("parent0_16", b16.parent0_idx, e.p0);
        chk("parent1_16", b16.parent1_idx, e.p1);
      end
    end
    if (b12.parent_valid) begin
      pv12_cnt++;
      pv12_last = cyc;
      chk("sb12_pending", q12.size() > 0, 1);
      if (q12.size() > 0) begin
        pair_t e;
        e = q12.pop_front();
        chk("parent0_12", b12.parent0_idx, e.p0);
        chk("parent1_12", b12.parent1_idx, e.p1);
      end
    end
  endtask

  task automatic zero_check(input string pre);
    chk({pre, "_fit_addr"}, b16.fit_addr, 0);
    chk({pre, "_sel_f1"},   b16.sel_fitness1, 0);
    chk({pre, "_sel_f2"},   b16.sel_fitness2, 0);
    chk({pre, "_sel_en"},   b16.sel_enable, 0);
    chk({pre, "_parent0"},  b16.parent0_idx, 0);
    chk({pre, "_parent1"},  b16.parent1_idx, 0);
    chk({pre, "_pvalid"},   b16.parent_valid, 0);
    chk({pre, "_busy"},     b16.busy, 0);
  endtask

  // start request on dut16: rand pair (a0,b0) at start, (a1,b1) afterwards
  task automatic launch16(input logic [3:0] a0, b0, a1, b1);
    clear_logs();
    b16.start = 1'b1; b16.rand_a = a0; b16.rand_b = b0;
    step();
    b16.start = 1'b0; b16.rand_a = a1; b16.rand_b = b1;
  endtask

  initial begin
    rst_n = 1'b0;
    b16.start = 1'b0; b16.rand_a = '0; b16.rand_b = '0;
    b12.start = 1'b0; b12.rand_a = '0; b12.rand_b = '0;
    for (int i = 0; i < 16; i++) mem16[i] = FIT_W'(100 - i);
    for (int i = 0; i < 12; i++) mem12[i] = FIT_W'(50);
    clear_logs();
    repeat (2) step();
    zero_check("rst");
    chk("rst_busy12", b12.busy, 0);
    rst_n = 1'b1;
    step();

    // 3/9 then 5/2: lower fitness wins -> 9, 5
    q16.push_back('{p0: 4'd9, p1: 4'd5});
    launch16(4'd3, 4'd9, 4'd5, 4'd2);
    chk("busy_active", b16.busy, 1);
    repeat (12) step();
    chk("t1_pv_count", pv16_cnt, 1);
    chk("t1_pv_cycle", pv16_first, 11);
    chk("t1_en_count", en16_cnt, 2);
    chk("t1_en_c4", en16[4], 1);
    chk("t1_en_c9", en16[9], 1);
    chk("t1_addr_c1", addr16[1], 3);
    chk("t1_addr_c2", addr16[2], 9);
    chk("t1_addr_hold", addr16[3], 9);
    chk("t1_addr_c6", addr16[6], 5);
    chk("t1_addr_c7", addr16[7], 2);
    chk("t1_busy_end", b16.busy, 0);
    chk("t1_p0_hold", b16.parent0_idx, 9);

    // 15/15 wraps B to 0; 7/7 becomes 7/8
    q16.push_back('{p0: 4'd15, p1: 4'd8});
    launch16(4'd15, 4'd15, 4'd7, 4'd7);
    repeat (12) step();
    chk("t2_addr_c1", addr16[1], 15);
    chk("t2_addr_c2", addr16[2], 0);
    chk("t2_addr_c6", addr16[6], 7);
    chk("t2_addr_c7", addr16[7], 8);
    chk("t2_pv_cycle", pv16_first, 11);

    // negative fitness: -5 vs 3 -> A, then 3 vs -5 -> B
    mem16[4] = -27'sd5;
    mem16[6] = 27'sd3;
    q16.push_back('{p0: 4'd4, p1: 4'd4});
    launch16(4'd4, 4'd6, 4'd6, 4'd4);
    repeat (12) step();
    chk("t3_f1_cmp", f1_16[4], -5);
    chk("t3_f2_cmp", f2_16[4], 3);
    chk("t3_f1_res", f1_16[5], -5);
    chk("t3_f2_res", f2_16[5], 3);
    chk("t3_f1_t1", f1_16[9], 3);
    chk("t3_f2_t1", f2_16[9], -5);
    chk("t3_pv_count", pv16_cnt, 1);

    // start held through busy: two requests, 12-cycle period
    q16.push_back('{p0: 4'd2, p1: 4'd10});
    q16.push_back('{p0: 4'd10, p1: 4'd10});
    clear_logs();
    b16.start = 1'b1; b16.rand_a = 4'd1; b16.rand_b = 4'd2;
    step();
    b16.rand_a = 4'd3; b16.rand_b = 4'd10;
    while (cyc < 13) step();
    b16.start = 1'b0;
    while (cyc < 25) step();
    chk("t4_pv_count", pv16_cnt, 2);
    chk("t4_pv_first", pv16_first, 11);
    chk("t4_pv_last", pv16_last, 23);
    chk("t4_en_count", en16_cnt, 4);

    // reset in CMP of tournament 1 aborts the request
    launch16(4'd5, 4'd6, 4'd7, 4'd8);
    while (cyc < 9) step();
    chk("t5_in_cmp", en16[9], 1);
    rst_n = 1'b0;
    step();
    zero_check("abort");
    rst_n = 1'b1;
    while (cyc < 20) step();
    chk("t5_no_pv", pv16_cnt, 0);
    chk("t5_idle", b16.busy, 0);

    // full request after the abort
    q16.push_back('{p0: 4'd6, p1: 4'd8});
    launch16(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (12) step();
    chk("t6_pv_count", pv16_cnt, 1);
    chk("t6_pv_cycle", pv16_first, 11);

    // POP_SIZE=12: 14/13 fold to 2/1, 11/11 wraps B to 0, equal fitness -> B
    q12.push_back('{p0: 4'd1, p1: 4'd0});
    clear_logs();
    b12.start = 1'b1; b12.rand_a = 4'd14; b12.rand_b = 4'd13;
    step();
    b12.start = 1'b0; b12.rand_a = 4'd11; b12.rand_b = 4'd11;
    repeat (12) step();
    chk("t7_addr_c1", addr12[1], 2);
    chk("t7_addr_c2", addr12[2], 1);
    chk("t7_addr_c6", addr12[6], 11);
    chk("t7_addr_c7", addr12[7], 0);
    chk("t7_pv_count", pv12_cnt, 1);
    chk("t7_pv_cycle", pv12_last, 11);

    chk("sb16_drained", q16.size(), 0);
    chk("sb12_drained", q12.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
